// File: rtl/or3_gate_bist_ctrl.sv
// BIST sequencer for a triple 2-input OR package: walks 12 vectors,
// samples each gate output after a settle window and reports per-gate faults.
module or3_gate_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter bit STOP_ON_FAIL  = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ABORT,
   input  logic       Y1,
   input  logic       Y2,
   input  logic       Y3,
   output logic       A1,
   output logic       B1,
   output logic       A2,
   output logic       B2,
   output logic       A3,
   output logic       B3,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [2:0] FAIL_MASK,
   output logic [3:0] FIRST_FAIL
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);
   localparam logic [3:0] LAST_IDX = 4'd11;
   localparam logic [3:0] NONE     = 4'hF;

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] mask_q, mask_d;
   logic [3:0] first_q, first_d;
   logic       pass_q, pass_d;

   logic       vec_a;
   logic       vec_b;
   logic       y_sel;
   logic       mismatch;
   logic [2:0] hit;
   logic [2:0] mask_new;

   // Pair order 11,01,10,00 falls straight out of the low index bits.
   always_comb begin
      vec_a = ~idx_q[0];
      vec_b = ~idx_q[1];
      y_sel = 1'b0;
      hit   = 3'b000;
      case (idx_q[3:2])
         2'd0:    y_sel = Y1;
         2'd1:    y_sel = Y2;
         2'd2:    y_sel = Y3;
         default: y_sel = 1'b0;
      endcase
      mismatch = (y_sel !== (vec_a | vec_b));
      if (mismatch) begin
         case (idx_q[3:2])
            2'd0:    hit = 3'b001;
            2'd1:    hit = 3'b010;
            2'd2:    hit = 3'b100;
            default: hit = 3'b000;
         endcase
      end
      mask_new = mask_q | hit;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         mask_q  <= 3'b000;
         first_q <= NONE;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      first_d = first_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (ABORT) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else if (START) begin
               state_d = S_RUN;
               idx_d   = 4'd0;
               cnt_d   = 4'd0;
               mask_d  = 3'b000;
               first_d = NONE;
               pass_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (ABORT) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
               cnt_d   = 4'd0;
               idx_d   = 4'd0;
            end else if (cnt_q == SETTLE) begin
               mask_d = mask_new;
               if (mismatch && first_q == NONE)
                  first_d = idx_q;
               cnt_d = 4'd0;
               if (idx_q == LAST_IDX || (STOP_ON_FAIL && mismatch)) begin
                  state_d = S_DONE;
                  pass_d  = (mask_new == 3'b000);
                  idx_d   = 4'd0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Only the gate under test sees stimulus; everything else parks at 0.
   always_comb begin
      A1 = 1'b0;
      B1 = 1'b0;
      A2 = 1'b0;
      B2 = 1'b0;
      A3 = 1'b0;
      B3 = 1'b0;
      if (state_q == S_RUN) begin
         case (idx_q[3:2])
            2'd0: begin
               A1 = vec_a;
               B1 = vec_b;
            end
            2'd1: begin
               A2 = vec_a;
               B2 = vec_b;
            end
            2'd2: begin
               A3 = vec_a;
               B3 = vec_b;
            end
            default: ;
         endcase
      end
      BUSY       = (state_q == S_RUN);
      DONE       = (state_q == S_DONE);
      PASS       = pass_q;
      FAIL_MASK  = mask_q;
      FIRST_FAIL = first_q;
   end

endmodule
